// File: rtl/bus_arbiter_pkg.sv
// Shared system-bus definitions for the two-master bus arbiter.
// Contents:
//   arb_state_t  : arbiter state encoding (IDLE, OWN0, OWN1)
//   MST_0/MST_1  : master index constants
//   MAX_HOLD_DEF : default consecutive-transfer budget for an unlocked owner
//   own_state()  : maps a master index to its ownership state
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic MST_0        = 1'b0;
  localparam logic MST_1        = 1'b1;
  localparam int   MAX_HOLD_DEF = 4;

  function automatic arb_state_t own_state(input logic idx);
    return (idx == MST_1) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the two master ports and the bridge-side bus.
// Modports:
//   slave  : arbiter view (takes requests, drives grants/ready/rdata and bus)
//   master : environment view (drives requests and bridge read data)
// Signals per master x: mx_req, mx_lock, mx_addr[31:0], mx_byteen[3:0],
//   mx_wdata[31:0] in; mx_gnt, mx_ready, mx_rdata[31:0] out.
// Bridge: bus_addr, bus_byteen, bus_wdata, bus_valid, bus_owner out;
//   bus_rdata in.
interface bus_arbiter_if;

  logic        m0_req;
  logic        m0_lock;
  logic [31:0] m0_addr;
  logic [3:0]  m0_byteen;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_lock;
  logic [31:0] m1_addr;
  logic [3:0]  m1_byteen;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_valid;
  logic        bus_owner;

  modport slave (
    input  m0_req, m0_lock, m0_addr, m0_byteen, m0_wdata,
    output m0_gnt, m0_ready, m0_rdata,
    input  m1_req, m1_lock, m1_addr, m1_byteen, m1_wdata,
    output m1_gnt, m1_ready, m1_rdata,
    output bus_addr, bus_byteen, bus_wdata, bus_valid, bus_owner,
    input  bus_rdata
  );

  modport master (
    output m0_req, m0_lock, m0_addr, m0_byteen, m0_wdata,
    input  m0_gnt, m0_ready, m0_rdata,
    output m1_req, m1_lock, m1_addr, m1_byteen, m1_wdata,
    input  m1_gnt, m1_ready, m1_rdata,
    input  bus_addr, bus_byteen, bus_wdata, bus_valid, bus_owner,
    output bus_rdata
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational two-way round-robin chooser.
// Ports:
//   i_req[1:0]   : request vector, bit x = master x
//   i_last_owner : master that most recently won the bus
//   o_winner     : chosen master index (valid when o_any)
//   o_any        : at least one request present
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_winner,
  output logic       o_any
);

  always_comb begin
    o_any    = |i_req;
    o_winner = MST_0;
    if (&i_req) begin
      // Tie: whoever did not own the bus last time goes first.
      o_winner = ~i_last_owner;
    end else if (i_req[1]) begin
      o_winner = MST_1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master system-bus arbiter (master 0 = CPU data port, master 1 = DMA).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : bus_arbiter_if.slave, both master ports plus bridge bus
// The owner's transfer is passed combinationally to the bridge in any owned
// cycle where it requests. An unlocked owner yields after MAX_HOLD transfers
// if the other master is waiting.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam int             HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);

  arb_state_t    r_state, w_state_next;
  logic          r_last_owner, w_last_owner_next;
  logic [HW-1:0] r_hold_cnt, w_hold_cnt_next, w_hold_inc;

  logic       w_owned, w_owner, w_own_req, w_own_lock, w_other_req, w_xfer;
  logic       w_pick, w_any;
  logic [1:0] w_req;

  assign w_req       = {bus.m1_req, bus.m0_req};
  assign w_owned     = (r_state != ST_IDLE);
  assign w_owner     = (r_state == ST_OWN1);
  assign w_own_req   = w_owner ? bus.m1_req  : bus.m0_req;
  assign w_own_lock  = w_owner ? bus.m1_lock : bus.m0_lock;
  assign w_other_req = w_owner ? bus.m0_req  : bus.m1_req;
  assign w_xfer      = w_owned & w_own_req;

  // Saturating so a long locked burst cannot wrap back below the budget.
  assign w_hold_inc = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;

  bus_arbiter_rr_pick u_rr_pick (
    .i_req        (w_req),
    .i_last_owner (r_last_owner),
    .o_winner     (w_pick),
    .o_any        (w_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_last_owner <= MST_1;
      r_hold_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_owner <= w_last_owner_next;
      r_hold_cnt   <= w_hold_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_last_owner_next = r_last_owner;
    w_hold_cnt_next   = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        w_hold_cnt_next = '0;
        if (w_any) begin
          w_state_next      = own_state(w_pick);
          w_last_owner_next = w_pick;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!w_own_req) begin
          w_hold_cnt_next = '0;
          if (w_other_req) begin
            w_state_next      = own_state(~w_owner);
            w_last_owner_next = ~w_owner;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if ((w_hold_inc == HOLD_MAX) && w_other_req && !w_own_lock) begin
          // Budget used up by this transfer and the other master is waiting.
          w_state_next      = own_state(~w_owner);
          w_last_owner_next = ~w_owner;
          w_hold_cnt_next   = '0;
        end else begin
          w_hold_cnt_next = w_hold_inc;
        end
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_hold_cnt_next = '0;
      end
    endcase
  end

  // Outputs decode only registered state and live inputs, so an asynchronous
  // reset forces them to zero without waiting for a clock edge.
  always_comb begin
    bus.m0_gnt     = (r_state == ST_OWN0);
    bus.m1_gnt     = (r_state == ST_OWN1);
    bus.bus_owner  = w_owner;
    bus.bus_valid  = 1'b0;
    bus.bus_addr   = '0;
    bus.bus_byteen = '0;
    bus.bus_wdata  = '0;
    bus.m0_ready   = 1'b0;
    bus.m1_ready   = 1'b0;
    bus.m0_rdata   = '0;
    bus.m1_rdata   = '0;
    if (w_xfer) begin
      bus.bus_valid = 1'b1;
      if (w_owner) begin
        bus.bus_addr   = bus.m1_addr;
        bus.bus_byteen = bus.m1_byteen;
        bus.bus_wdata  = bus.m1_wdata;
        bus.m1_ready   = 1'b1;
        bus.m1_rdata   = bus.bus_rdata;
      end else begin
        bus.bus_addr   = bus.m0_addr;
        bus.bus_byteen = bus.m0_byteen;
        bus.bus_wdata  = bus.m0_wdata;
        bus.m0_ready   = 1'b1;
        bus.m0_rdata   = bus.bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random
// request/lock traffic, all compared against a behavioural ownership model.
module tb_bus_arbiter;

  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if bif ();

  bus_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  logic        t_req  [2];
  logic        t_lock [2];
  logic [31:0] t_addr [2];
  logic [3:0]  t_be   [2];
  logic [31:0] t_wd   [2];
  logic [31:0] t_rdata;

  assign bif.m0_req    = t_req[0];
  assign bif.m0_lock   = t_lock[0];
  assign bif.m0_addr   = t_addr[0];
  assign bif.m0_byteen = t_be[0];
  assign bif.m0_wdata  = t_wd[0];
  assign bif.m1_req    = t_req[1];
  assign bif.m1_lock   = t_lock[1];
  assign bif.m1_addr   = t_addr[1];
  assign bif.m1_byteen = t_be[1];
  assign bif.m1_wdata  = t_wd[1];
  assign bif.bus_rdata = t_rdata;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus (-1 = nobody), who won last, and how
  // many transfers the current owner has made (capped at MAXH).
  int m_owner = -1;
  int m_last  = 1;
  int m_run   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_run   = 0;
  endtask

  task automatic model_step();
    int o;
    int other;
    if (m_owner < 0) begin
      if (t_req[0] || t_req[1]) begin
        if (t_req[0] && t_req[1]) m_owner = 1 - m_last;
        else m_owner = t_req[0] ? 0 : 1;
        m_last = m_owner;
        m_run  = 0;
      end
    end else begin
      o = m_owner;
      other = 1 - o;
      if (!t_req[o]) begin
        m_run = 0;
        if (t_req[other]) begin
          m_owner = other;
          m_last  = other;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_run = (m_run < MAXH) ? m_run + 1 : MAXH;
        if (m_run == MAXH && t_req[other] && !t_lock[o]) begin
          m_owner = other;
          m_last  = other;
          m_run   = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic xfer;
    int o;
    o = (m_owner < 0) ? 0 : m_owner;
    xfer = (m_owner >= 0) && t_req[o];
    chk({tag, ".m0_gnt"},  bif.m0_gnt,  m_owner == 0);
    chk({tag, ".m1_gnt"},  bif.m1_gnt,  m_owner == 1);
    chk({tag, ".owner"},   bif.bus_owner, m_owner == 1);
    chk({tag, ".valid"},   bif.bus_valid, xfer);
    chk({tag, ".addr"},    bif.bus_addr,   xfer ? t_addr[o] : 32'h0);
    chk({tag, ".byteen"},  bif.bus_byteen, xfer ? t_be[o]   : 4'h0);
    chk({tag, ".wdata"},   bif.bus_wdata,  xfer ? t_wd[o]   : 32'h0);
    chk({tag, ".m0_rdy"},  bif.m0_ready, xfer && o == 0);
    chk({tag, ".m1_rdy"},  bif.m1_ready, xfer && o == 1);
    chk({tag, ".m0_rd"},   bif.m0_rdata, (xfer && o == 0) ? t_rdata : 32'h0);
    chk({tag, ".m1_rd"},   bif.m1_rdata, (xfer && o == 1) ? t_rdata : 32'h0);
    chk({tag, ".hold"},    32'(dut.r_hold_cnt), m_run);
    if (xfer)
      $display("txn %s owner=%0d addr=%08h be=%h wdata=%08h rdata=%08h",
               tag, o, t_addr[o], t_be[o], t_wd[o], t_rdata);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic sample(input string tag);
    #1;
    check_outputs(tag);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_in(input logic r0, input logic l0, input logic r1, input logic l1);
    t_req[0]  = r0;
    t_lock[0] = l0;
    t_req[1]  = r1;
    t_lock[1] = l1;
    for (int k = 0; k < 2; k++) begin
      t_addr[k] = $urandom;
      t_be[k]   = 4'($urandom_range(0, 15));
      t_wd[k]   = $urandom;
    end
    t_rdata = $urandom;
  endtask

  // Assert reset between clock edges, check the immediate effect, release on
  // the next falling edge.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int cnt;
    bit seen;
    set_in(0, 0, 0, 0);

    // Held in reset
    #12;
    check_outputs("in_reset");
    @(negedge clk);
    reset = 1'b1;

    // First grant after reset release: write from M0
    set_in(1, 0, 0, 0);
    t_addr[0] = 32'h0000_1004;
    t_be[0]   = 4'hF;
    t_wd[0]   = 32'hDEAD_BEEF;
    sample("w_req");
    chk("w_req_gnt", bif.m0_gnt, 1'b0);
    chk("w_req_valid", bif.bus_valid, 1'b0);
    advance();
    sample("w_xfer");
    chk("w_xfer_gnt", bif.m0_gnt, 1'b1);
    chk("w_xfer_valid", bif.bus_valid, 1'b1);
    chk("w_xfer_addr", bif.bus_addr, 32'h0000_1004);
    chk("w_xfer_rdy", bif.m0_ready, 1'b1);
    advance();
    set_in(0, 0, 0, 0);
    sample("w_drop");
    advance();
    sample("w_idle");
    advance();

    // Round-robin tie-break
    pulse_reset("rr_rst");
    set_in(1, 0, 1, 0);
    sample("rr_req1");
    advance();
    sample("rr_own1");
    chk("rr_first_m0", bif.m0_gnt, 1'b1);
    chk("rr_first_m1", bif.m1_gnt, 1'b0);
    advance();
    set_in(0, 0, 0, 0);
    sample("rr_drop");
    advance();
    sample("rr_idle");
    advance();
    set_in(1, 0, 1, 0);
    sample("rr_req2");
    advance();
    sample("rr_own2");
    chk("rr_second_m1", bif.m1_gnt, 1'b1);
    chk("rr_second_m0", bif.m0_gnt, 1'b0);
    advance();

    // Preemption after MAX_HOLD reads
    pulse_reset("pre_rst");
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      set_in(1, 0, 1, 0);
      t_be[0] = 4'h0;
      sample("pre");
      if (bif.m1_gnt === 1'b1) begin
        seen = 1;
        chk("pre_hold_zero", 32'(dut.r_hold_cnt), 32'd0);
      end else begin
        if (bif.m0_ready === 1'b1) cnt++;
        advance();
      end
    end
    chk("pre_m1_granted", seen, 1'b1);
    chk("pre_pulses", cnt, MAXH);
    advance();

    // Locked owner keeps the bus
    pulse_reset("lck_rst");
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 11; i++) begin
      set_in(1, 1, 1, 0);
      sample("lck");
      if (bif.m0_ready === 1'b1) cnt++;
      if (bif.m1_gnt === 1'b1) seen = 1;
      advance();
    end
    chk("lck_pulses", cnt, 10);
    chk("lck_no_m1", seen, 1'b0);
    set_in(0, 1, 1, 0);
    sample("lck_drop");
    chk("lck_drop_rdy", bif.m0_ready, 1'b0);
    advance();
    sample("lck_handoff");
    chk("lck_handoff_m1", bif.m1_gnt, 1'b1);
    advance();

    // M1 read data routing, then reset mid-transfer
    pulse_reset("rd_rst");
    set_in(0, 0, 1, 0);
    t_addr[1] = 32'h0000_7F04;
    t_be[1]   = 4'h0;
    t_rdata   = 32'h1234_5678;
    sample("rd_req");
    advance();
    sample("rd_xfer");
    chk("rd_m1_rdata", bif.m1_rdata, 32'h1234_5678);
    chk("rd_m0_rdata", bif.m0_rdata, 32'h0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rd_abort_rdy", bif.m1_ready, 1'b0);
    chk("rd_abort_valid", bif.bus_valid, 1'b0);
    chk("rd_abort_gnt", bif.m1_gnt, 1'b0);
    check_outputs("rd_abort");
    @(negedge clk);
    reset = 1'b1;
    sample("rd_restart_req");
    chk("rd_restart_nognt", bif.m1_gnt, 1'b0);
    advance();
    sample("rd_restart_gnt");
    chk("rd_restart_m1", bif.m1_gnt, 1'b1);
    advance();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
      sample("rnd");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4: consecutive transfers an unlocked owner may make while the other master waits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-004 m0_req  input  1  master 0 (CPU data port) requests a transfer this cycle.
REQ-005 m0_lock  input  1  master 0 holds the bus past MAX_HOLD while asserted with m0_req.
REQ-006 m0_addr  input  32  master 0 byte address.
REQ-007 m0_byteen  input  4  master 0 write byte enables; 0 means read.
REQ-008 m0_wdata  input  32  master 0 write data.
REQ-009 m0_gnt  output  1  master 0 owns the bus.
REQ-010 m0_ready  output  1  master 0 transfer completes this cycle.
REQ-011 m0_rdata  output  32  master 0 read data, valid when m0_ready.
REQ-012 m1_req, m1_lock, m1_addr, m1_byteen, m1_wdata, m1_gnt, m1_ready, m1_rdata: master 1 (DMA port), same directions, widths and meanings as REQ-004..011.
REQ-013 bus_addr  output  32  address to bridge.
REQ-014 bus_byteen  output  4  byte enables to bridge.
REQ-015 bus_wdata  output  32  write data to bridge.
REQ-016 bus_rdata  input  32  read data from bridge, combinational on bus_addr.
REQ-017 bus_valid  output  1  a transfer is on the bus this cycle.
REQ-018 bus_owner  output  1  index of current owner; 0 when idle.

Function
REQ-019 States: IDLE, OWN0, OWN1; registered; exactly one of m0_gnt/m1_gnt high in OWNx, none in IDLE.
REQ-020 Grant latency: request first seen in IDLE -> gnt high the next cycle; no transfer in the request cycle.
REQ-021 IDLE, one requester -> OWN of that master; both -> master other than last_owner (round-robin).
REQ-022 Transfer: cycle in OWNx with mx_req=1; bus_valid=1, mx_ready=1, bus_addr/byteen/wdata = owner inputs combinationally, mx_rdata = bus_rdata.
REQ-023 Non-transfer cycles: bus_valid=0, bus_addr=0, bus_byteen=0, bus_wdata=0; both ready=0; both rdata=0; non-owner rdata always 0.
REQ-024 hold_cnt, width clog2(MAX_HOLD+1), increments per transfer, saturates at MAX_HOLD, clears on every ownership change and in IDLE.
REQ-025 OWNx, mx_req=0 -> OWN other if other requests, else IDLE; gnt drops next cycle.
REQ-026 OWNx, transfer that makes hold_cnt reach MAX_HOLD, other requesting, mx_lock=0 -> OWN other next cycle (preemption after that transfer).
REQ-027 mx_lock=1 suppresses preemption indefinitely; lock sampled only from the owner; non-owner lock ignored.
REQ-028 last_owner updates on every entry into OWNx.
REQ-029 Owner requesting without competitor keeps the bus regardless of hold_cnt.

Reset
REQ-030 Reset low: state IDLE, last_owner=1 (M0 wins first tie), hold_cnt=0, all outputs 0, applied asynchronously.
REQ-031 Reset mid-transfer aborts it: ready, bus_valid, bus_byteen go 0 without waiting for clk; after release, arbitration restarts per REQ-020.

Structure
REQ-032 State encoding, master index constants and MAX_HOLD default reside in the shared system-bus definitions package.
REQ-033 One sub-module, rr_pick: combinational two-way round-robin chooser (req vector, last_owner -> winner, any).

Verification
REQ-034 Reset release, m0_req=1, m0_addr=0x0000_1004, byteen=0xF, wdata=0xDEADBEEF -> cycle 1 m0_gnt=1, same cycle bus_valid=1, bus_addr=0x1004, m0_ready=1.
REQ-035 Both request from IDLE after reset -> M0 granted; both drop and re-request -> M1 granted.
REQ-036 M0 streams reads, M1 waiting, lock=0, MAX_HOLD=4 -> exactly 4 m0_ready pulses, then m1_gnt=1 next cycle, hold_cnt=0.
REQ-037 Same as REQ-036 with m0_lock=1 -> M0 keeps grant for 10 transfers; M1 granted the cycle after m0_req falls.
REQ-038 M1 owning, bus_rdata=0x12345678, read at 0x7F04 -> m1_rdata=0x12345678, m0_rdata=0; reset pulsed low mid-cycle -> m1_ready, bus_valid 0 immediately, state IDLE.
